reg_wb_arbiter: RTL and testbench

Write-back arbiter and register scoreboard for the RV32I core's 32×32 register file. It shares the register file's single write port between two write-back requesters, the ALU and the LSU, using fixed priority with starvation protection. It registers the granted write onto the register-file port and tracks which architectural registers have an in-flight producer, so the issue stage can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file's write port, and beside the decode/issue logic.

---
 rtl/reg_wb_arbiter_pkg.sv | 24 ++
 rtl/reg_wb_arbiter_wb_scoreboard.sv | 57 +++++
 rtl/reg_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its register scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    // Width of the data field in the write-back record. The top-level XLEN
    // defaults to this value and must match it.
    localparam int WB_DATA_W  = 32;

    // Which requester wins a contested write-back cycle.
    typedef enum logic {
        ALU_FIRST = 1'b0,
        LSU_FIRST = 1'b1
    } prio_state_e;

    // One register-file write: destination register plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_rec_t;

endpackage

// File: rtl/reg_wb_arbiter_wb_scoreboard.sv
// Register busy scoreboard: marks registers with an in-flight producer and raises a stall on RAW/WAW hazards.
// Latency: stall is combinational from the issue addresses; set/clear take effect at the next clock edge.
// Backpressure: o_stall holds the issue stage; no new register is marked while the stall is high.
//
// Ports:
//   clk, i_rst                        clock, synchronous active-high reset (clears every busy bit)
//   i_issue_valid/i_issue_rd          instruction presented by issue, its destination (0 = no write)
//   i_rs1_addr/i_rs2_addr             its source registers
//   i_clr_en/i_clr_addr               write-back retiring a producer of i_clr_addr
//   o_stall                           hold the presented instruction
module reg_wb_arbiter_wb_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    output logic                  o_stall
);

    // Bit 0 is kept in the vector so any 5-bit address indexes it directly,
    // but it is forced to zero on every update: x0 never has a producer.
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_en;

    assign o_stall = i_issue_valid &
                     (busy_q[i_rs1_addr] | busy_q[i_rs2_addr] | busy_q[i_issue_rd]);

    assign set_en = i_issue_valid & ~o_stall & (i_issue_rd != '0);

    always_comb begin
        busy_d = busy_q;
        if (i_clr_en) begin
            busy_d[i_clr_addr] = 1'b0;
        end
        // Applied after the clear: a fresh producer of the same register
        // must stay marked even while the old one retires.
        if (set_en) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: shares the register file's single write port between ALU and LSU, with LSU starvation protection.
// Latency: 1 cycle from grant (valid & ready) to the registered o_rf_we/addr/data; one write per cycle.
// Backpressure: o_alu_ready/o_lsu_ready are combinational grants; a requester holds until its ready is high.
//
// Ports:
//   clk, i_rst                          clock, synchronous active-high reset
//   i_issue_valid/rd, i_rs1/2_addr      issue-stage instruction; o_stall holds it on RAW/WAW hazard
//   i_alu_*/o_alu_ready                 ALU write-back request and grant
//   i_lsu_*/o_lsu_ready                 LSU write-back request and grant
//   o_rf_we/o_rf_rd_addr/o_rf_rd_data   registered register-file write port
//   o_fwd_rsN, o_fwd_rsN_sel            operand forwarding from the write port (WB_FORWARD_EN only)
//
// Build option: define WB_FORWARD_EN to retire busy bits at the grant edge and
// forward the in-flight write to the issue operands; otherwise busy bits retire
// when the register file has latched the write.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = WB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_stall,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_lsu_valid,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    output logic                  o_lsu_ready,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]       o_rf_rd_data
`ifdef WB_FORWARD_EN
    ,
    output logic [XLEN-1:0]       o_fwd_rs1,
    output logic [XLEN-1:0]       o_fwd_rs2,
    output logic                  o_fwd_rs1_sel,
    output logic                  o_fwd_rs2_sel
`endif
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    prio_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    wb_rec_t              wb_q, wb_d;
    wb_rec_t              gnt_rec;
    logic                 alu_gnt, lsu_gnt;
    logic                 clr_en;
    logic [REG_ADDR_W-1:0] clr_addr;

    // Arbitration and priority/starvation next state.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!i_rst) begin
            case (state_q)
                ALU_FIRST: begin
                    alu_gnt = i_alu_valid;
                    lsu_gnt = i_lsu_valid & ~i_alu_valid;
                end
                LSU_FIRST: begin
                    lsu_gnt = i_lsu_valid;
                    alu_gnt = i_alu_valid & ~i_lsu_valid;
                end
            endcase
        end

        // Counts consecutive cycles the LSU has been left waiting.
        cnt_d = '0;
        if (i_lsu_valid && !lsu_gnt) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end

        state_d = state_q;
        if (state_q == LSU_FIRST && lsu_gnt) begin
            state_d = ALU_FIRST;
        end else if (cnt_d == CNT_MAX) begin
            // Flip on the cycle the count reaches the limit so the LSU is
            // served on the very next cycle.
            state_d = LSU_FIRST;
        end
    end

    assign o_alu_ready = alu_gnt;
    assign o_lsu_ready = lsu_gnt;

    // Granted write; rd==0 transfers are accepted but never reach the file.
    always_comb begin
        gnt_rec = lsu_gnt ? '{rd: i_lsu_rd, data: i_lsu_data}
                          : '{rd: i_alu_rd, data: i_alu_data};
        we_d    = (alu_gnt | lsu_gnt) & (gnt_rec.rd != '0);
        wb_d    = we_d ? gnt_rec : wb_q;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ALU_FIRST;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wb_q    <= wb_d;
        end
    end

    assign o_rf_we      = we_q;
    assign o_rf_rd_addr = wb_q.rd;
    assign o_rf_rd_data = wb_q.data;

`ifdef WB_FORWARD_EN
    // Retire at the grant edge; the write-port cycle forwards the value.
    assign clr_en   = we_d;
    assign clr_addr = gnt_rec.rd;

    assign o_fwd_rs1     = wb_q.data;
    assign o_fwd_rs2     = wb_q.data;
    assign o_fwd_rs1_sel = we_q & (wb_q.rd == i_rs1_addr) & (i_rs1_addr != '0);
    assign o_fwd_rs2_sel = we_q & (wb_q.rd == i_rs2_addr) & (i_rs2_addr != '0);
`else
    // Retire only once the register file has latched the write.
    assign clr_en   = we_q;
    assign clr_addr = wb_q.rd;
`endif

    reg_wb_arbiter_wb_scoreboard u_scoreboard (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_clr_en      (clr_en),
        .i_clr_addr    (clr_addr),
        .o_stall       (o_stall)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: randomized and directed write-back/issue traffic against a reference model.
// Latency: expectations for the write port are tagged with the cycle they must appear in.
// Backpressure: requesters hold their payload until the model says they were granted.
module tb_reg_wb_arbiter;

    localparam int STARVE = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Cycles between the grant and the edge that retires the busy bit.
    localparam int CLR_DLY = FWD ? 0 : 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst = 1'b1;
    logic        i_issue_valid = 1'b0;
    logic [4:0]  i_issue_rd = '0, i_rs1_addr = '0, i_rs2_addr = '0;
    logic        o_stall;
    logic        i_alu_valid = 1'b0, i_lsu_valid = 1'b0;
    logic [4:0]  i_alu_rd = '0, i_lsu_rd = '0;
    logic [31:0] i_alu_data = '0, i_lsu_data = '0;
    logic        o_alu_ready, o_lsu_ready;
    logic        o_rf_we;
    logic [4:0]  o_rf_rd_addr;
    logic [31:0] o_rf_rd_data;
`ifdef WB_FORWARD_EN
    logic [31:0] o_fwd_rs1, o_fwd_rs2;
    logic        o_fwd_rs1_sel, o_fwd_rs2_sel;
`endif

    reg_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(STARVE)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_stall       (o_stall),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .o_alu_ready   (o_alu_ready),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .o_rf_we       (o_rf_we),
        .o_rf_rd_addr  (o_rf_rd_addr),
        .o_rf_rd_data  (o_rf_rd_data)
`ifdef WB_FORWARD_EN
        ,
        .o_fwd_rs1     (o_fwd_rs1),
        .o_fwd_rs2     (o_fwd_rs2),
        .o_fwd_rs1_sel (o_fwd_rs1_sel),
        .o_fwd_rs2_sel (o_fwd_rs2_sel)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues.
    typedef struct { int c; logic [4:0] rd; logic [31:0] d; } wr_t;
    typedef struct { int c; bit ra; bit rl; bit st; bit f1; bit f2; logic [31:0] fd; } exp_t;
    typedef struct { int c; logic [4:0] rd; } clr_t;
    wr_t  wr_q[$];
    exp_t exp_q[$];

    // Reference model state.
    bit          busy_m[32];
    clr_t        clr_q[$];
    int          lsu_wait = 0;
    bit          lsu_pri  = 1'b0;
    bit          lw_v     = 1'b0;
    logic [4:0]  lw_rd    = '0;
    logic [31:0] lw_dat   = '0;

    // Drives one cycle of inputs and records what the model expects of it.
    task automatic drive(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input bit iv, input logic [4:0] ird, input logic [4:0] r1,
                         input logic [4:0] r2, output bit ga, output bit gl);
        exp_t e;
        @(posedge clk);
        #1;
        i_rst = rst; i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
        i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ld;
        i_issue_valid = iv; i_issue_rd = ird; i_rs1_addr = r1; i_rs2_addr = r2;

        e.c  = cyc;
        e.st = iv && (busy_m[r1] || busy_m[r2] || busy_m[ird]);
        e.f1 = lw_v && (lw_rd == r1) && (r1 != 0);
        e.f2 = lw_v && (lw_rd == r2) && (r2 != 0);
        e.fd = lw_dat;

        ga = 1'b0; gl = 1'b0;
        if (!rst) begin
            if (lsu_pri) begin gl = lv; ga = av && !lv; end
            else         begin ga = av; gl = lv && !av; end
        end
        e.ra = ga; e.rl = gl;
        exp_q.push_back(e);

        lw_v = 1'b0;
        if (ga && ard != 0) begin lw_v = 1'b1; lw_rd = ard; lw_dat = ad; end
        if (gl && lrd != 0) begin lw_v = 1'b1; lw_rd = lrd; lw_dat = ld; end
        if (lw_v) begin
            wr_q.push_back('{c: cyc + 1, rd: lw_rd, d: lw_dat});
            clr_q.push_back('{c: cyc + CLR_DLY, rd: lw_rd});
        end

        if (rst) begin
            lsu_wait = 0; lsu_pri = 1'b0;
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            clr_q.delete();
        end else begin
            if (lv && !gl) lsu_wait++; else lsu_wait = 0;
            if (gl && lsu_pri) lsu_pri = 1'b0;
            else if (lsu_wait >= STARVE) lsu_pri = 1'b1;
            while (clr_q.size() != 0 && clr_q[0].c == cyc) begin
                busy_m[clr_q[0].rd] = 1'b0;
                void'(clr_q.pop_front());
            end
            if (iv && !e.st && ird != 0) busy_m[ird] = 1'b1;
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    int   n_cmp = 0, n_bad = 0;
    bit   done = 1'b0, fin = 1'b0;
    bit   exp_we;
    wr_t  w;
    exp_t e_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && !fin) begin
            exp_we = (wr_q.size() != 0) && (wr_q[0].c == cyc);
            chk("rf_we", 32'(o_rf_we), 32'(exp_we));
            if (exp_we) begin
                w = wr_q.pop_front();
                if (o_rf_we) begin
                    chk("rf_addr", 32'(o_rf_rd_addr), 32'(w.rd));
                    chk("rf_data", o_rf_rd_data, w.d);
                end
            end
            if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
                e_m = exp_q.pop_front();
                chk("alu_ready", 32'(o_alu_ready), 32'(e_m.ra));
                chk("lsu_ready", 32'(o_lsu_ready), 32'(e_m.rl));
                chk("stall", 32'(o_stall), 32'(e_m.st));
`ifdef WB_FORWARD_EN
                chk("fwd_rs1_sel", 32'(o_fwd_rs1_sel), 32'(e_m.f1));
                chk("fwd_rs2_sel", 32'(o_fwd_rs2_sel), 32'(e_m.f2));
                if (e_m.f1) chk("fwd_rs1", o_fwd_rs1, e_m.fd);
                if (e_m.f2) chk("fwd_rs2", o_fwd_rs2, e_m.fd);
`endif
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            chk("writes_drained", 32'(wr_q.size()), 32'd0);
            chk("cycles_drained", 32'(exp_q.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Stimulus.
    initial begin
        bit          ga, gl, a_pend, l_pend, rst_r, iv;
        logic [4:0]  a_rd, l_rd, ird, r1, r2;
        logic [31:0] a_d, l_d;
        a_pend = 1'b0; l_pend = 1'b0;
        a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;

        // Reset with both requesters asserting: no grants allowed.
        drive(1, 1, 5'd5, 32'h1111, 1, 5'd6, 32'h2222, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(1, 1, 5'd5, 32'h1111, 1, 5'd6, 32'h2222, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        // Clean scoreboard: no stall for arbitrary addresses.
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd13, 5'd31, ga, gl);

        // Contention: ALU first, then the LSU.
        drive(0, 1, 5'd5, 32'hAAAA, 1, 5'd6, 32'hBBBB, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    1, 5'd6, 32'hBBBB, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, ga, gl);

        // Starvation: ALU always valid, LSU held until granted.
        l_pend = 1'b1; l_rd = 5'd2; l_d = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 5'd1, 32'h100 + i, l_pend, l_rd, l_d, 0, 5'd0, 5'd0, 5'd0, ga, gl);
            if (gl) l_pend = 1'b0;
        end
        // Back to ALU priority.
        drive(0, 1, 5'd1, 32'h200, 1, 5'd2, 32'h300, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,   1, 5'd2, 32'h300, 0, 5'd0, 5'd0, 5'd0, ga, gl);

        // RAW hazard on x7.
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd0, ga, gl);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd7, 5'd0, ga, gl);
        drive(0, 1, 5'd7, 32'hC0FF_EE01, 0, 5'd0, 32'h0, 1, 5'd0, 5'd7, 5'd0, ga, gl);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd7, 5'd7, ga, gl);

        // Write-back to x0: accepted, never written.
        drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 5'd1, 5'd2, ga, gl);
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,    1, 5'd0, 5'd0, 5'd0, ga, gl);

        // Grant and new issue of x3 in the same cycle, then a new issue while x3 retires.
        drive(0, 1, 5'd3, 32'h3333, 0, 5'd0, 32'h0, 1, 5'd3, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd0, 5'd3, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd0, 5'd3, 5'd0, ga, gl);
        drive(0, 1, 5'd3, 32'h4444, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd3, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd0, 5'd3, 5'd0, ga, gl);

        // Reset while a write is registered.
        drive(0, 1, 5'd4, 32'h4040, 0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd0, ga, gl);
        drive(1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd0, 5'd9, 5'd3, ga, gl);

        // Random traffic with held requests and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            if (!a_pend && $urandom_range(0, 9) < 7) begin
                a_pend = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_d = $urandom;
            end
            if (!l_pend && $urandom_range(0, 9) < 5) begin
                l_pend = 1'b1; l_rd = 5'($urandom_range(0, 7)); l_d = $urandom;
            end
            iv  = ($urandom_range(0, 1) == 1);
            ird = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            drive(rst_r, a_pend, a_rd, a_d, l_pend, l_rd, l_d, iv, ird, r1, r2, ga, gl);
            if (ga) a_pend = 1'b0;
            if (gl) l_pend = 1'b0;
        end

        for (int i = 0; i < 3; i++)
            drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        done = 1'b1;
    end

endmodule
